// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 16-bit TSC datapath.
// Sequences IF/ID/EX/MEM/WB/HALT and counts retired instructions.
module multicycle_control #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           opcode,
  input  logic [5:0]           func,
  input  logic                 bcond,
  input  logic                 mem_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 i_or_d,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic [1:0]           imm_sel,
  output logic                 alu_src_b,
  output logic                 reg_write,
  output logic [1:0]           reg_dst,
  output logic [1:0]           wb_src,
  output logic                 wwd_valid,
  output logic                 halted,
  output logic [WORD_SIZE-1:0] num_inst
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [WORD_SIZE-1:0] num_inst_q, num_inst_d;
  logic                 retire;

  logic op_f;
  logic is_r, is_adi, is_ori, is_lhi, is_lwd, is_swd, is_br;
  logic is_jmp, is_jal, is_jpr, is_jrl, is_wwd, is_hlt;
  logic is_alu_i, to_ex;

  assign op_f     = (opcode == 4'hF);
  assign is_r     = op_f && (func[5:3] == 3'b000);
  assign is_adi   = (opcode == 4'd4);
  assign is_ori   = (opcode == 4'd5);
  assign is_lhi   = (opcode == 4'd6);
  assign is_lwd   = (opcode == 4'd7);
  assign is_swd   = (opcode == 4'd8);
  assign is_br    = (opcode[3:2] == 2'b00);
  assign is_jmp   = (opcode == 4'd9);
  assign is_jal   = (opcode == 4'd10);
  assign is_jpr   = op_f && (func == 6'd25);
  assign is_jrl   = op_f && (func == 6'd26);
  assign is_wwd   = op_f && (func == 6'd28);
  assign is_hlt   = op_f && (func == 6'd29);
  assign is_alu_i = is_adi | is_ori | is_lhi;
  assign to_ex    = is_r | is_alu_i | is_lwd | is_swd | is_br;

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    i_or_d    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    imm_sel   = 2'b00;
    alu_src_b = 1'b0;
    reg_write = 1'b0;
    reg_dst   = 2'b00;
    wb_src    = 2'b00;
    wwd_valid = 1'b0;
    halted    = 1'b0;
    // Outputs are forced quiet for the whole reset pulse.
    if (!reset) begin
      unique case (state_q)
        S_IF: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_ID;
          end
        end
        S_ID: begin
          unique case (1'b1)
            to_ex:  state_d = S_EX;
            is_jal: state_d = S_WB;
            is_jrl: state_d = S_WB;
            is_jmp: begin
              pc_write = 1'b1;
              pc_src   = 2'b10;
              retire   = 1'b1;
              state_d  = S_IF;
            end
            is_jpr: begin
              pc_write = 1'b1;
              pc_src   = 2'b11;
              retire   = 1'b1;
              state_d  = S_IF;
            end
            is_wwd: begin
              wwd_valid = 1'b1;
              retire    = 1'b1;
              state_d   = S_IF;
            end
            is_hlt: begin
              retire  = 1'b1;
              state_d = S_HALT;
            end
            default: begin
              retire  = 1'b1;
              state_d = S_IF;
            end
          endcase
        end
        S_EX: begin
          imm_sel   = is_ori ? 2'b01 : (is_lhi ? 2'b10 : 2'b00);
          alu_src_b = is_alu_i | is_lwd | is_swd;
          if (is_lwd || is_swd) begin
            state_d = S_MEM;
          end else if (is_br) begin
            pc_write = bcond;
            pc_src   = 2'b01;
            retire   = 1'b1;
            state_d  = S_IF;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = is_lwd;
          mem_write = is_swd;
          if (mem_ready) begin
            if (is_lwd) begin
              state_d = S_WB;
            end else begin
              retire  = 1'b1;
              state_d = S_IF;
            end
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          state_d   = S_IF;
          if (is_r) reg_dst = 2'b01;
          if (is_lwd) wb_src = 2'b01;
          if (is_jal || is_jrl) begin
            reg_dst  = 2'b10;
            wb_src   = 2'b10;
            pc_write = 1'b1;
            pc_src   = is_jrl ? 2'b11 : 2'b10;
          end
        end
        S_HALT: halted = 1'b1;
        default: state_d = S_IF;
      endcase
    end
  end

  assign num_inst_d = num_inst_q + {{(WORD_SIZE-1){1'b0}}, retire};
  assign num_inst   = num_inst_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IF;
      num_inst_q <= '0;
    end else begin
      state_q    <= state_d;
      num_inst_q <= num_inst_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control.
// A narrow-counter instance covers the retire-count wrap.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic [5:0]  func;
  logic        bcond;
  logic        mem_ready;
  logic        mem_read, mem_write, i_or_d, ir_write, pc_write;
  logic [1:0]  pc_src, imm_sel, reg_dst, wb_src;
  logic        alu_src_b, reg_write, wwd_valid, halted;
  logic [15:0] num_inst;

  logic        mr8, mw8, iod8, irw8, pcw8, asb8, rw8, wwd8, hlt8;
  logic [1:0]  pcs8, imm8, rd8, wb8;
  logic [7:0]  num8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_control #(.WORD_SIZE(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func),
    .bcond(bcond), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .imm_sel(imm_sel), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .reg_dst(reg_dst), .wb_src(wb_src), .wwd_valid(wwd_valid),
    .halted(halted), .num_inst(num_inst)
  );

  multicycle_control #(.WORD_SIZE(8)) dut8 (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func),
    .bcond(bcond), .mem_ready(mem_ready),
    .mem_read(mr8), .mem_write(mw8), .i_or_d(iod8),
    .ir_write(irw8), .pc_write(pcw8), .pc_src(pcs8),
    .imm_sel(imm8), .alu_src_b(asb8), .reg_write(rw8),
    .reg_dst(rd8), .wb_src(wb8), .wwd_valid(wwd8),
    .halted(hlt8), .num_inst(num8)
  );

  logic [16:0] ctl;
  assign ctl = {mem_read, mem_write, i_or_d, ir_write, pc_write,
                pc_src, imm_sel, alu_src_b, reg_write, reg_dst,
                wb_src, wwd_valid, halted};

  function automatic logic [16:0] mk(
    input logic mr, input logic mw, input logic iod,
    input logic irw, input logic pcw, input logic [1:0] pcs,
    input logic [1:0] imm, input logic asb, input logic rw,
    input logic [1:0] rd, input logic [1:0] wb,
    input logic wwd, input logic hlt);
    return {mr, mw, iod, irw, pcw, pcs, imm, asb, rw, rd, wb, wwd, hlt};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs are driven at the falling edge; outputs sampled 1 ns later.
  task automatic cyc(input string tag, input logic [16:0] exp);
    #1;
    check(tag, {15'd0, ctl}, {15'd0, exp});
    @(negedge clk);
  endtask

  logic [16:0] c_idle, c_if_go, c_if_wait, c_ex_imm;
  logic [16:0] c_mem_rd, c_mem_wr, c_wb_i;

  initial begin
    #20_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    c_idle    = '0;
    c_if_go   = mk(1,0,0,1,1,2'b00,2'b00,0,0,2'b00,2'b00,0,0);
    c_if_wait = mk(1,0,0,0,0,2'b00,2'b00,0,0,2'b00,2'b00,0,0);
    c_ex_imm  = mk(0,0,0,0,0,2'b00,2'b00,1,0,2'b00,2'b00,0,0);
    c_mem_rd  = mk(1,0,1,0,0,2'b00,2'b00,0,0,2'b00,2'b00,0,0);
    c_mem_wr  = mk(0,1,1,0,0,2'b00,2'b00,0,0,2'b00,2'b00,0,0);
    c_wb_i    = mk(0,0,0,0,0,2'b00,2'b00,0,1,2'b00,2'b00,0,0);

    reset = 1'b1; opcode = 4'd4; func = 6'd0;
    bcond = 1'b0; mem_ready = 1'b1;
    #1;
    check("rst_ctl", {15'd0, ctl}, 32'd0);
    check("rst_num", {16'd0, num_inst}, 32'd0);
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_ctl_ready", {15'd0, ctl}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // ADI
    opcode = 4'd4;
    cyc("adi_if", c_if_go);
    cyc("adi_id", c_idle);
    cyc("adi_ex", c_ex_imm);
    cyc("adi_wb", c_wb_i);
    check("adi_num", {16'd0, num_inst}, 32'd1);

    // LWD with IF and MEM stalls
    opcode = 4'd7; mem_ready = 1'b0;
    cyc("lwd_if_wait", c_if_wait);
    mem_ready = 1'b1;
    cyc("lwd_if", c_if_go);
    cyc("lwd_id", c_idle);
    cyc("lwd_ex", c_ex_imm);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lwd_mem_wait", c_mem_rd);
    mem_ready = 1'b1;
    cyc("lwd_mem", c_mem_rd);
    cyc("lwd_wb", mk(0,0,0,0,0,2'b00,2'b00,0,1,2'b00,2'b01,0,0));
    check("lwd_num", {16'd0, num_inst}, 32'd2);

    // SWD retires on the ready cycle in MEM
    opcode = 4'd8;
    cyc("swd_if", c_if_go);
    cyc("swd_id", c_idle);
    cyc("swd_ex", c_ex_imm);
    mem_ready = 1'b0;
    cyc("swd_mem_wait", c_mem_wr);
    mem_ready = 1'b1;
    cyc("swd_mem", c_mem_wr);
    check("swd_num", {16'd0, num_inst}, 32'd3);

    // R-type ALU
    opcode = 4'hF; func = 6'd2;
    cyc("r_if", c_if_go);
    cyc("r_id", c_idle);
    cyc("r_ex", c_idle);
    cyc("r_wb", mk(0,0,0,0,0,2'b00,2'b00,0,1,2'b01,2'b00,0,0));

    // ORI / LHI immediate modes
    opcode = 4'd5;
    cyc("ori_if", c_if_go);
    cyc("ori_id", c_idle);
    cyc("ori_ex", mk(0,0,0,0,0,2'b00,2'b01,1,0,2'b00,2'b00,0,0));
    cyc("ori_wb", c_wb_i);
    opcode = 4'd6;
    cyc("lhi_if", c_if_go);
    cyc("lhi_id", c_idle);
    cyc("lhi_ex", mk(0,0,0,0,0,2'b00,2'b10,1,0,2'b00,2'b00,0,0));
    cyc("lhi_wb", c_wb_i);
    check("imm_num", {16'd0, num_inst}, 32'd6);

    // BEQ taken then not taken
    opcode = 4'd1; bcond = 1'b1;
    cyc("beq_t_if", c_if_go);
    cyc("beq_t_id", c_idle);
    cyc("beq_t_ex", mk(0,0,0,0,1,2'b01,2'b00,0,0,2'b00,2'b00,0,0));
    bcond = 1'b0;
    cyc("beq_n_if", c_if_go);
    cyc("beq_n_id", c_idle);
    cyc("beq_n_ex", mk(0,0,0,0,0,2'b01,2'b00,0,0,2'b00,2'b00,0,0));
    check("beq_num", {16'd0, num_inst}, 32'd8);

    // JAL
    opcode = 4'd10;
    cyc("jal_if", c_if_go);
    cyc("jal_id", c_idle);
    cyc("jal_wb", mk(0,0,0,0,1,2'b10,2'b00,0,1,2'b10,2'b10,0,0));
    check("jal_num", {16'd0, num_inst}, 32'd9);

    // JMP, JPR, JRL
    opcode = 4'd9;
    cyc("jmp_if", c_if_go);
    cyc("jmp_id", mk(0,0,0,0,1,2'b10,2'b00,0,0,2'b00,2'b00,0,0));
    opcode = 4'hF; func = 6'd25;
    cyc("jpr_if", c_if_go);
    cyc("jpr_id", mk(0,0,0,0,1,2'b11,2'b00,0,0,2'b00,2'b00,0,0));
    func = 6'd26;
    cyc("jrl_if", c_if_go);
    cyc("jrl_id", c_idle);
    cyc("jrl_wb", mk(0,0,0,0,1,2'b11,2'b00,0,1,2'b10,2'b10,0,0));
    check("jump_num", {16'd0, num_inst}, 32'd12);

    // WWD then HLT from a fresh reset
    reset = 1'b1;
    #1;
    check("rst2_num", {16'd0, num_inst}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    opcode = 4'hF; func = 6'd28;
    cyc("wwd_if", c_if_go);
    cyc("wwd_id", mk(0,0,0,0,0,2'b00,2'b00,0,0,2'b00,2'b00,1,0));
    func = 6'd29;
    cyc("hlt_if", c_if_go);
    cyc("hlt_id", c_idle);
    for (int i = 0; i < 20; i++) cyc("halt", mk(0,0,0,0,0,2'b00,2'b00,0,0,2'b00,2'b00,0,1));
    check("halt_num", {16'd0, num_inst}, 32'd2);

    // NOP stream: narrow counter wraps, wide one does not
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    opcode = 4'd11; func = 6'd0; mem_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk); @(negedge clk);
    end
    check("nop_num16_ff", {16'd0, num_inst}, 32'h00FF);
    check("nop_num8_ff", {24'd0, num8}, 32'hFF);
    cyc("nop_if", c_if_go);
    cyc("nop_id", c_idle);
    check("nop_num16_100", {16'd0, num_inst}, 32'h0100);
    check("nop_num8_wrap", {24'd0, num8}, 32'h00);

    // Reset asserted mid-wait in MEM
    opcode = 4'd7;
    cyc("rm_if", c_if_go);
    cyc("rm_id", c_idle);
    cyc("rm_ex", c_ex_imm);
    mem_ready = 1'b0;
    cyc("rm_mem_wait", c_mem_rd);
    reset = 1'b1;
    #1;
    check("rm_rst_ctl", {15'd0, ctl}, 32'd0);
    check("rm_rst_num", {16'd0, num_inst}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc("rm_refetch", c_if_wait);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
